// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Sequences the PC / instruction-fetch path of the five-stage RISC-V core. It
// owns the fetch address and presents it to instruction memory through a
// req/ready handshake. Each cycle it chooses between three actions, in this
// priority order:
//   1. an EX-stage redirect,
//   2. a hazard-unit stall,
//   3. a sequential advance on imem_ready.
// It also produces the IF/ID valid bit and the pipeline flush strobes.
// A misaligned redirect or a memory timeout halts the sequencer with a sticky
// error code. Only reset leaves the halted state.
//
// Every output is driven straight from a flop.
//
// Ports
//   clock        in   system clock; all state updates on the rising edge
//   reset        in   synchronous, active-high; dominates every other input
//   stall        in   hazard-unit hold (load-use); freezes fetch
//   redirect     in   one-cycle strobe for a taken branch/jump resolved in EX
//   redirect_pc  in   [31:0] redirect target, valid while redirect=1
//   imem_ready   in   memory accepts imem_addr and returns its data this cycle
//   imem_req     out  fetch request valid
//   imem_addr    out  [31:0] current fetch address
//   pc           out  [31:0] PC of the instruction entering IF/ID
//   if_valid     out  IF/ID holds a valid fetched instruction
//   flush_ifid   out  one-cycle IF/ID squash
//   flush_idex   out  one-cycle ID/EX squash (always equal to flush_ifid)
//   err          out  [1:0] sticky error: 00 none, 01 misaligned redirect,
//                     10 fetch timeout
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0100_0000,
  parameter int unsigned BOOT_CYCLES = 2,   // 1..15
  parameter int unsigned TIMEOUT     = 16   // 2..255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic        if_valid,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic [1:0]  err
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10
  } err_e;

  // Terminal counts. Each one is reached on the last cycle of its window, so
  // that cycle's decision already performs the transition.
  localparam logic [3:0] BOOT_LAST    = 4'(BOOT_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q,     state_d;
  logic [3:0]  boot_cnt_q,  boot_cnt_d;
  logic [7:0]  wait_cnt_q,  wait_cnt_d;
  logic        imem_req_q,  imem_req_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic [31:0] pc_q,        pc_d;
  logic        if_valid_q,  if_valid_d;
  logic        flush_q,     flush_d;
  err_e        err_q,       err_d;

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case statement. A path that
    // leaves a signal unassigned in combinational logic infers a latch.
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    imem_req_d  = imem_req_q;
    imem_addr_d = imem_addr_q;
    pc_d        = pc_q;
    if_valid_d  = if_valid_q;
    flush_d     = 1'b0;          // flushes are strobes: high for one cycle only
    err_d       = err_q;

    unique case (state_q)
      ST_BOOT: begin
        // Inputs are ignored while booting.
        imem_req_d = 1'b0;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d     = ST_RUN;
          imem_req_d  = 1'b1;
          imem_addr_d = RESET_PC;
        end else begin
          boot_cnt_d = boot_cnt_q + 4'd1;
        end
      end

      ST_RUN, ST_WAIT: begin
        if (redirect) begin
          // Any data returned alongside a redirect belongs to the squashed
          // path and is dropped.
          if_valid_d = 1'b0;
          flush_d    = 1'b1;
          if (redirect_pc[1:0] == 2'b00) begin
            imem_addr_d = redirect_pc;
            wait_cnt_d  = '0;
            state_d     = ST_RUN;
          end else begin
            err_d      = ERR_MISALIGN;
            imem_req_d = 1'b0;
            state_d    = ST_HALT;
          end
        end else if (stall) begin
          // Hold everything, the wait count included. A ready seen this cycle
          // is ignored, so the same address is fetched again after the stall.
        end else if (imem_ready) begin
          pc_d        = imem_addr_q;
          if_valid_d  = 1'b1;
          imem_addr_d = imem_addr_q + 32'd4;   // wraps modulo 2^32
          wait_cnt_d  = '0;
          state_d     = ST_RUN;
        end else begin
          if_valid_d = 1'b0;
          if (wait_cnt_q == TIMEOUT_LAST) begin
            err_d      = ERR_TIMEOUT;
            imem_req_d = 1'b0;
            state_d    = ST_HALT;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
            state_d    = ST_WAIT;
          end
        end
      end

      ST_HALT: begin
        // Frozen until reset. err, pc and imem_addr keep their defaults.
        imem_req_d = 1'b0;
        if_valid_d = 1'b0;
      end

      default: state_d = ST_BOOT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers (synchronous reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments. Every flop then
    // samples pre-edge values, whatever order these statements are in.
    if (reset) begin
      state_q     <= ST_BOOT;
      boot_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_PC;
      pc_q        <= RESET_PC;
      if_valid_q  <= 1'b0;
      flush_q     <= 1'b0;
      err_q       <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      pc_q        <= pc_d;
      if_valid_q  <= if_valid_d;
      flush_q     <= flush_d;
      err_q       <= err_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign pc         = pc_q;
  assign if_valid   = if_valid_q;
  // One flop drives both squashes, so they can never disagree.
  assign flush_ifid = flush_q;
  assign flush_idex = flush_q;
  assign err        = err_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controller that sequences the PC/instruction-fetch path of the five-stage RISC-V core. It owns the fetch address and presents it to instruction memory with a req/ready handshake. It arbitrates between sequential advance, EX-stage redirects and hazard-unit stalls, and generates IF/ID valid and pipeline flush strobes. Illegal redirects and memory timeouts halt it with a sticky error.

Parameters:
RESET_PC, 32'h01000000, fetch address loaded on reset.
BOOT_CYCLES, 2, idle cycles after reset deasserts before the first request; range 1..15.
TIMEOUT, 16, maximum consecutive cycles waiting on imem_ready before an error; range 2..255.

Ports:
clock  input  1  system clock, all state updates on rising edge.
reset  input  1  synchronous, active-high.
stall  input  1  hazard-unit hold (load-use); freezes fetch.
redirect  input  1  taken branch or jump resolved in EX; one-cycle strobe.
redirect_pc  input  32  redirect target, valid when redirect=1.
imem_ready  input  1  instruction memory accepts and returns data for imem_addr this cycle.
imem_req  output  1  fetch request valid.
imem_addr  output  32  current fetch address.
pc  output  32  PC of the instruction entering IF/ID.
if_valid  output  1  IF/ID holds a valid fetched instruction.
flush_ifid  output  1  one-cycle IF/ID squash.
flush_idex  output  1  one-cycle ID/EX squash.
err  output  2  sticky error code: 00 none, 01 misaligned redirect, 10 fetch timeout.

Behaviour:
- All outputs are registered. Reset dominates every other input in every state, including mid-wait and HALT.
- Reset values: imem_req=0, imem_addr=RESET_PC, pc=RESET_PC, if_valid=0, flush_ifid=0, flush_idex=0, err=00, state=BOOT, boot count=0, wait count=0.
- States: BOOT, RUN, WAIT, HALT.
- BOOT:
  - imem_req=0; count cycles.
  - After BOOT_CYCLES cycles, go to RUN with imem_req=1 and imem_addr=RESET_PC.
  - Inputs are ignored in BOOT.
- RUN and WAIT: imem_req=1. Per-cycle priority is redirect > stall > imem_ready.
  - Redirect, aligned (redirect_pc[1:0]==00):
    - Next cycle: imem_addr=redirect_pc, if_valid=0, flush_ifid=1, flush_idex=1 (both for exactly one cycle).
    - Go to RUN; wait count cleared.
    - Redirect overrides a simultaneous stall and imem_ready; the data returned that cycle is discarded.
  - Redirect, misaligned:
    - Next cycle: err=01, imem_req=0, if_valid=0, both flushes=1 for one cycle.
    - Go to HALT.
  - Stall, no redirect:
    - imem_addr, pc and if_valid hold; flushes=0; wait count holds.
    - Any imem_ready that cycle is ignored (fetch is replayed).
  - imem_ready, no stall:
    - pc<=imem_addr, if_valid<=1, imem_addr<=imem_addr+4 (modulo 2^32, so 32'hFFFFFFFC wraps to 0).
    - Go to RUN; wait count cleared.
  - No imem_ready, no stall:
    - if_valid<=0; address holds; wait count increments; go to WAIT.
    - When the wait count reaches TIMEOUT: err=10, imem_req=0, go to HALT.
- Latency: the instruction whose ready handshake completes in cycle N has pc/if_valid visible in cycle N+1. Redirect to first request at the new target is 1 cycle.
- HALT:
  - imem_req=0, if_valid=0, flushes=0; err, pc and imem_addr frozen.
  - Only reset exits HALT.
- flush_ifid and flush_idex are always equal and never asserted two cycles in a row unless redirect is asserted on consecutive cycles.

Test Plan:
1. Reset then release with BOOT_CYCLES=2, imem_ready=1 constantly -> imem_req rises on the 3rd cycle after release at 01000000. pc/if_valid show 01000000, 01000004, 01000008 on successive cycles.
2. Running at imem_addr=01000010; assert redirect with redirect_pc=01000100 together with stall=1 -> next cycle imem_addr=01000100, if_valid=0, single-cycle flush_ifid=flush_idex=1. Following cycle pc=01000100, if_valid=1.
3. stall=1 for 3 cycles at imem_addr=01000020 with imem_ready=1 -> pc, imem_addr and if_valid frozen for 3 cycles. Release resumes with pc=01000020.
4. imem_ready=0 for 5 cycles then 1 (TIMEOUT=16) -> if_valid=0 during the wait, address held, err=00. Fetch completes normally.
5. imem_ready held 0 with TIMEOUT=16 -> err=10 and imem_req=0 after the 16th waiting cycle. Stays frozen until reset, which restores BOOT and RESET_PC.
6. redirect_pc=01000102 -> err=01, one-cycle flushes, HALT. Also cover address wrap: start a fetch at FFFFFFFC with ready=1 -> next imem_addr=00000000.
